// File: rtl/sti_pkg.sv
// rtl/sti_pkg.sv - shared types and helpers for the serial byte packer
package sti_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } pack_state_t;

  function automatic logic even_par(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

  // n valid bits sit in the LSBs of v; move them to the top and zero-fill below
  function automatic logic [BYTE_W-1:0] left_align(input logic [BYTE_W-1:0] v, input logic [2:0] n);
    return v << (4'd8 - {1'b0, n});
  endfunction

endpackage

// File: rtl/sti_byte_packer_if.sv
// rtl/sti_byte_packer_if.sv - serial input, byte handshake and status bundle of the packer
interface sti_byte_packer_if #(
  parameter int AW = 2
);
  import sti_pkg::*;

  logic              so_data;
  logic              so_valid;
  logic              stream_end;
  logic [BYTE_W-1:0] byte_data;
  logic              byte_valid;
  logic              byte_ready;
  logic              byte_par;
  logic [7:0]        byte_cnt;
  logic [AW:0]       fifo_level;
  logic              overflow;
  logic              proto_err;
  logic              pack_done;

  modport master (
    input  so_data, so_valid, stream_end, byte_ready,
    output byte_data, byte_valid, byte_par, byte_cnt, fifo_level, overflow, proto_err, pack_done
  );

  modport slave (
    output so_data, so_valid, stream_end, byte_ready,
    input  byte_data, byte_valid, byte_par, byte_cnt, fifo_level, overflow, proto_err, pack_done
  );

endinterface

// File: rtl/sti_sync_fifo.sv
// rtl/sti_sync_fifo.sv - synchronous FIFO with a registered head word
module sti_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d, rd_nx;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_pop, do_push;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == LVL_FULL);
  assign do_pop  = pop_i & ~empty_o;
  // a full FIFO still accepts a write when the head leaves on the same edge
  assign do_push = push_i & (~full_o | do_pop);
  assign rd_nx   = rd_q + 1'b1;

  always_comb begin
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    head_d = head_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_nx;
    if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
    if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
    if (do_pop) begin
      if (cnt_q == LVL_ONE) head_d = do_push ? wdata_i : head_q;
      else                  head_d = mem[rd_nx];
    end else if (empty_o && do_push) begin
      head_d = wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end

  assign head_o  = head_q;
  assign level_o = cnt_q;

endmodule

// File: rtl/sti_byte_packer.sv
// rtl/sti_byte_packer.sv - MSB-first bit-to-byte packer with output FIFO
// STI_PACK_PARITY_EN stores even parity with each byte and drives byte_par.
module sti_byte_packer
  import sti_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic               clk,
  input logic               reset,
  sti_byte_packer_if.master bus
);

`ifdef STI_PACK_PARITY_EN
  localparam int FW = BYTE_W + 1;
`else
  localparam int FW = BYTE_W;
`endif

  localparam logic [AW:0] LVL_ONE = (AW+1)'(1);

  pack_state_t       state_q, state_d;
  logic [BYTE_W-1:0] sreg_q, sreg_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              perr_q, perr_d;
  logic              push;
  logic [BYTE_W-1:0] push_data;
  logic [BYTE_W-1:0] shifted;
  logic [FW-1:0]     fifo_wdata, fifo_head;
  logic              fifo_full, fifo_empty, pop;
  logic [AW:0]       fifo_level;

  assign pop     = bus.byte_ready & ~fifo_empty;
  assign shifted = {sreg_q[BYTE_W-2:0], bus.so_data};

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    bit_d     = bit_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    perr_d    = perr_q;
    push      = 1'b0;
    push_data = shifted;
    case (state_q)
      RUN: begin
        if (bus.so_valid) begin
          sreg_d = shifted;
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) push = 1'b1;
        end
        // bit_d already counts a coincident final bit, so a full byte never flushes twice
        if (bus.stream_end) begin
          state_d = DRAIN;
          if (bit_d != 3'd0) begin
            push      = 1'b1;
            push_data = left_align(sreg_d, bit_d);
          end
          sreg_d = '0;
          bit_d  = '0;
        end
      end
      DRAIN: begin
        if (bus.so_valid) perr_d = 1'b1;
        if (fifo_level == '0 || (fifo_level == LVL_ONE && pop)) state_d = DONE;
      end
      DONE: begin
        if (bus.so_valid) perr_d = 1'b1;
      end
      default: state_d = RUN;
    endcase
    if (push) cnt_d = cnt_q + 8'd1;
    if (push && fifo_full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      sreg_q  <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      perr_q  <= perr_d;
    end
  end

`ifdef STI_PACK_PARITY_EN
  assign fifo_wdata   = {even_par(push_data), push_data};
  assign bus.byte_par = fifo_head[BYTE_W];
`else
  assign fifo_wdata   = push_data;
  assign bus.byte_par = 1'b0;
`endif

  sti_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign bus.byte_data  = fifo_head[BYTE_W-1:0];
  assign bus.byte_valid = ~fifo_empty;
  assign bus.byte_cnt   = cnt_q;
  assign bus.fifo_level = fifo_level;
  assign bus.overflow   = ovf_q;
  assign bus.proto_err  = perr_q;
  assign bus.pack_done  = (state_q == DONE);

endmodule
